// File: rtl/rst_seq_gen_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
package rst_seq_gen_pkg;

    // Sequencer phases: initial hold, staggered per-channel release, all released.
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Width of the shared cycle counter; it must hold the larger of the two intervals.
    function automatic int cnt_width(input int hold, input int stagger);
        int m;
        m = (hold > stagger) ? hold : stagger;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: holds all NUM_CH resets asserted, releases
// channel 0 after HOLD_CYC edges and each later channel STAGGER_CYC edges
// after its predecessor. i_async_rst asserts every output without a clock;
// i_soft_rst re-triggers the sequence synchronously and is level-sensitive.
// Optional build macro RST_SEQ_GEN_READY_GATE_EN adds i_ch_ready: channel k+1
// additionally waits for i_ch_ready[k] before it is released.
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYC    = 2,
    parameter int STAGGER_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_async_rst,
    input  logic              i_soft_rst,
`ifdef RST_SEQ_GEN_READY_GATE_EN
    input  logic [NUM_CH-1:0] i_ch_ready,
`endif
    output logic [NUM_CH-1:0] o_rst,
    output logic              o_busy,
    output logic              o_done,
    output state_t            o_state
);

    localparam int CNT_W = cnt_width(HOLD_CYC, STAGGER_CYC);
    localparam int CH_W  = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    if (NUM_CH < 1 || HOLD_CYC < 1 || STAGGER_CYC < 1) begin : g_param_check
        $error("rst_seq_gen: NUM_CH, HOLD_CYC and STAGGER_CYC must all be >= 1");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;    // edges elapsed in the current interval
    logic [CH_W-1:0]     ch_q, ch_d;      // next channel to release
    logic [NUM_CH-1:0]   rst_q, rst_d;
    logic                done_q, done_d;
    logic                prev_ready;      // predecessor of ch_q reports stable

`ifdef RST_SEQ_GEN_READY_GATE_EN
    // Select the acknowledgement of the channel released just before ch_q.
    always_comb begin
        prev_ready = 1'b0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            if (ch_q == CH_W'(k + 1)) prev_ready = i_ch_ready[k];
        end
    end
`else
    assign prev_ready = 1'b1;
`endif

    // Next-state logic: soft reset overrides everything, otherwise advance the sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        done_d  = done_q;
        if (i_soft_rst) begin
            state_d = HOLD;
            cnt_d   = '0;
            ch_d    = '0;
            rst_d   = '1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        ch_d     = CH_W'(1);
                        if (NUM_CH == 1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    // Counter saturates at the stagger limit while a ready gate holds the release.
                    if (cnt_q == STAG_LAST) begin
                        if (prev_ready) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (ch_q == CH_W'(k)) rst_d[k] = 1'b0;
                            end
                            cnt_d = '0;
                            if (ch_q == CH_LAST) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Static until a reset source asserts.
                end
                default: state_d = HOLD;
            endcase
        end
    end

    // State register; async reset forces every output asserted without a clock.
    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    assign o_rst   = rst_q;
    assign o_done  = done_q;
    assign o_busy  = ~done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: a 4-channel instance (HOLD 2, STAGGER 3) and a
// 1-channel instance (HOLD 1) share clock and reset inputs. The driver pushes
// the reference model's expectation after every edge; a negedge monitor pops
// and compares.
module tb_rst_seq_gen;
    localparam int N      = 4;
    localparam int P_HOLD = 2;
    localparam int P_ST   = 3;
    localparam int W      = N + 4;   // {rst, busy, done, state}

    logic         clk       = 1'b0;
    logic         async_rst = 1'b0;
    logic         soft_rst  = 1'b0;
`ifdef RST_SEQ_GEN_READY_GATE_EN
    logic [N-1:0] ch_ready  = '0;
`endif
    logic [N-1:0] rst_o;
    logic         busy_o, done_o;
    logic [1:0]   state_o;
    logic [0:0]   rst1_o;
    logic         busy1_o, done1_o;
    logic [1:0]   state1_o;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [4:0]   exp1_q[$];
    bit           started = 1'b0;

    // Reference model: qualifying edges since the last reset, and the edge
    // number at which each channel was released (-1 = still asserted).
    int           e_cnt = 0;
    int           rel[N];

    always #5 clk = ~clk;

    rst_seq_gen #(.NUM_CH(N), .HOLD_CYC(P_HOLD), .STAGGER_CYC(P_ST)) u_dut (
        .i_clk       (clk),
        .i_async_rst (async_rst),
        .i_soft_rst  (soft_rst),
`ifdef RST_SEQ_GEN_READY_GATE_EN
        .i_ch_ready  (ch_ready),
`endif
        .o_rst       (rst_o),
        .o_busy      (busy_o),
        .o_done      (done_o),
        .o_state     (state_o)
    );

    rst_seq_gen #(.NUM_CH(1), .HOLD_CYC(1), .STAGGER_CYC(1)) u_dut1 (
        .i_clk       (clk),
        .i_async_rst (async_rst),
        .i_soft_rst  (soft_rst),
`ifdef RST_SEQ_GEN_READY_GATE_EN
        .i_ch_ready  (1'b0),
`endif
        .o_rst       (rst1_o),
        .o_busy      (busy1_o),
        .o_done      (done1_o),
        .o_state     (state1_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance the model by one edge given the inputs sampled there, push expectations.
    task automatic model_edge(input bit a, input bit s, input logic [N-1:0] rdy);
        logic [N-1:0] r;
        logic         d;
        int           st;
        if (a || s) begin
            e_cnt = 0;
            for (int k = 0; k < N; k++) rel[k] = -1;
        end else begin
            e_cnt++;
            if (e_cnt == P_HOLD) rel[0] = e_cnt;
            for (int k = 1; k < N; k++) begin
                if (rel[k] < 0 && rel[k-1] >= 0 && e_cnt >= rel[k-1] + P_ST && rdy[k-1])
                    rel[k] = e_cnt;
            end
        end
        for (int k = 0; k < N; k++) r[k] = (rel[k] < 0);
        d  = (rel[N-1] >= 0);
        st = d ? 2 : ((rel[0] >= 0) ? 1 : 0);
        exp_q.push_back({r, ~d, d, 2'(st)});
        if (e_cnt >= 1) exp1_q.push_back(5'b0_0_1_10);
        else            exp1_q.push_back(5'b1_1_0_00);
    endtask

    // Drive inputs for the coming edge, then record the model's view of it.
    task automatic tick(input bit a, input bit s);
        logic [N-1:0] rdy;
        async_rst = a;
        soft_rst  = s;
`ifdef RST_SEQ_GEN_READY_GATE_EN
        ch_ready = N'($urandom_range(0, (1 << N) - 1));
        rdy      = ch_ready;
`else
        rdy      = '1;
`endif
        @(posedge clk);
        #1;
        model_edge(a, s, rdy);
        started = 1'b1;
    endtask

    // Raise the async reset between edges and confirm outputs react without a clock.
    task automatic async_mid();
        @(negedge clk);
        #2;
        async_rst = 1'b1;
        #1;
        check("async_imm4", 32'({rst_o, busy_o, done_o}), 32'({{N{1'b1}}, 2'b10}));
        check("async_imm1", 32'({rst1_o, busy1_o, done1_o}), 32'(3'b110));
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() == 0 || exp1_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL underflow: got empty queue expected an entry");
            end else begin
                check("seq4", 32'({rst_o, busy_o, done_o, state_o}), 32'(exp_q.pop_front()));
                check("seq1", 32'({rst1_o, busy1_o, done1_o, state1_o}), 32'(exp1_q.pop_front()));
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) rel[k] = -1;
        async_rst = 1'b1;
        #1;
        check("reset4", 32'({rst_o, busy_o, done_o, state_o}), 32'({{N{1'b1}}, 4'b1000}));
        check("reset1", 32'({rst1_o, busy1_o, done1_o, state1_o}), 32'(5'b11000));
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        // Plain release after async reset.
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        // Soft reset pulse at edge 6.
        async_mid();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        // Soft reset on the release edge of channel 2 (edge 8).
        async_mid();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        // Async reset mid-cycle after edge 9, then a full restart.
        async_mid();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
        async_mid();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        // Both resets high, async dropped while soft stays high for 5 edges.
        async_mid();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        // Randomized soft/async activity.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_mid();
                tick(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                tick(1'b0, $urandom_range(0, 15) == 0);
            end
        end
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size() + exp1_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
